// File: rtl/sobel_window_gen_pkg.sv
// Shared constants for the Sobel 3x3 window generator.
// Holds the pixel width and the default image geometry.
package sobel_window_gen_pkg;

    localparam int PIXEL_WIDTH_OUT = 8;
    localparam int IMG_WIDTH_DEF   = 640;
    localparam int IMG_HEIGHT_DEF  = 480;
    localparam int TAP_COUNT       = 9;

endpackage

// File: rtl/sobel_window_gen_line_buffer.sv
// One image line of flop storage.
// Reads are asynchronous and writes are synchronous at the same address, so a read returns the old value.
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel datapath.
// Two line buffers feed the right column of a shifting register window; only interior windows are flagged.
module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PIXEL_WIDTH_OUT-1:0] pixel_i,
    input  logic                       pixel_valid_i,
    input  logic                       sof_i,
    output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o0,
    output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o1,
    output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o2,
    output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o3,
    output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o4,
    output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o5,
    output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o6,
    output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o7,
    output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o8,
    output logic                       window_valid_o,
    output logic                       frame_done_o
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]           col_r;
    logic [ROW_W-1:0]           row_r;
    logic [COL_W-1:0]           col_s;
    logic [ROW_W-1:0]           row_s;
    logic [COL_W-1:0]           col_nxt_s;
    logic [ROW_W-1:0]           row_nxt_s;
    logic                       wr_en_s;
    logic                       interior_s;
    logic                       last_s;
    logic [PIXEL_WIDTH_OUT-1:0] lb0_rdata_s;
    logic [PIXEL_WIDTH_OUT-1:0] lb1_rdata_s;
    logic [PIXEL_WIDTH_OUT-1:0] win_r [TAP_COUNT];
    logic                       valid_r;
    logic                       done_r;

    // Position of the current beat; sof forces (0, 0) regardless of the counters.
    always_comb begin
        col_s = col_r;
        row_s = row_r;
        if (sof_i) begin
            col_s = COL_W'(0);
            row_s = ROW_W'(0);
        end else begin
            col_s = col_r;
            row_s = row_r;
        end
    end

    // Raster advance from the current beat position, wrapping at line and frame end.
    always_comb begin
        col_nxt_s = col_s + COL_W'(1);
        row_nxt_s = row_s;
        if (col_s == COL_LAST) begin
            col_nxt_s = COL_W'(0);
            if (row_s == ROW_LAST) begin
                row_nxt_s = ROW_W'(0);
            end else begin
                row_nxt_s = row_s + ROW_W'(1);
            end
        end else begin
            row_nxt_s = row_s;
        end
    end

    assign wr_en_s    = pixel_valid_i & ~rst_i;
    assign interior_s = (row_s >= ROW_W'(2)) && (col_s >= COL_W'(2));
    assign last_s     = (row_s == ROW_LAST) && (col_s == COL_LAST);

    // lb1 holds the previous row; lb0 receives what lb1 is about to lose (two rows back).
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIXEL_WIDTH_OUT)
    ) lb0 (
        .clk   (clk_i),
        .addr  (col_s),
        .wr_en (wr_en_s),
        .wdata (lb1_rdata_s),
        .rdata (lb0_rdata_s)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIXEL_WIDTH_OUT)
    ) lb1 (
        .clk   (clk_i),
        .addr  (col_s),
        .wr_en (wr_en_s),
        .wdata (pixel_i),
        .rdata (lb1_rdata_s)
    );

    // Counters, window shift and valid/done flags; idle cycles hold state and drop the flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_r   <= COL_W'(0);
            row_r   <= ROW_W'(0);
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            for (int i = 0; i < TAP_COUNT; i++) begin
                win_r[i] <= PIXEL_WIDTH_OUT'(0);
            end
        end else if (pixel_valid_i) begin
            col_r    <= col_nxt_s;
            row_r    <= row_nxt_s;
            win_r[0] <= win_r[1];
            win_r[1] <= win_r[2];
            win_r[2] <= lb0_rdata_s;
            win_r[3] <= win_r[4];
            win_r[4] <= win_r[5];
            win_r[5] <= lb1_rdata_s;
            win_r[6] <= win_r[7];
            win_r[7] <= win_r[8];
            win_r[8] <= pixel_i;
            valid_r  <= interior_s;
            done_r   <= last_s;
        end else begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end
    end

    assign matrix_pixels_o0 = win_r[0];
    assign matrix_pixels_o1 = win_r[1];
    assign matrix_pixels_o2 = win_r[2];
    assign matrix_pixels_o3 = win_r[3];
    assign matrix_pixels_o4 = win_r[4];
    assign matrix_pixels_o5 = win_r[5];
    assign matrix_pixels_o6 = win_r[6];
    assign matrix_pixels_o7 = win_r[7];
    assign matrix_pixels_o8 = win_r[8];
    assign window_valid_o   = valid_r;
    assign frame_done_o     = done_r;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 image with pixel = 5r + c.
// Each accepted beat is followed by a check of flags and taps against the expected neighbourhood.
module tb_sobel_window_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;

    logic          clk;
    logic          rst;
    logic [PW-1:0] pixel;
    logic          pixel_valid;
    logic          sof;
    logic [PW-1:0] taps [9];
    logic          wv;
    logic          fd;

    int checks;
    int errors;
    int windows;
    int dones;
    int offs [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

    sobel_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pixel_i          (pixel),
        .pixel_valid_i    (pixel_valid),
        .sof_i            (sof),
        .matrix_pixels_o0 (taps[0]),
        .matrix_pixels_o1 (taps[1]),
        .matrix_pixels_o2 (taps[2]),
        .matrix_pixels_o3 (taps[3]),
        .matrix_pixels_o4 (taps[4]),
        .matrix_pixels_o5 (taps[5]),
        .matrix_pixels_o6 (taps[6]),
        .matrix_pixels_o7 (taps[7]),
        .matrix_pixels_o8 (taps[8]),
        .window_valid_o   (wv),
        .frame_done_o     (fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle and sample #1 after the rising edge.
    task automatic cycle(input logic v, input logic [PW-1:0] pix, input logic s, input logic r);
        @(negedge clk);
        rst         = r;
        pixel_valid = v;
        pixel       = pix;
        sof         = s;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        pixel_valid = 1'b0;
        sof         = 1'b0;
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s_tap%0d", tag, i), 32'(taps[i]), 32'd0);
        end
        check({tag, "_valid"}, 32'(wv), 32'd0);
        check({tag, "_done"}, 32'(fd), 32'd0);
    endtask

    // Expected outputs after a beat at (r, c) of a stream whose (0,0) pixel is off.
    task automatic check_beat(input string tag, input int r, input int c, input int off);
        logic ev;
        logic ed;
        int   base;
        ev = (r >= 2) && (c >= 2);
        ed = (r == H - 1) && (c == W - 1);
        check($sformatf("%s_r%0dc%0d_valid", tag, r, c), 32'(wv), 32'(ev));
        check($sformatf("%s_r%0dc%0d_done", tag, r, c), 32'(fd), 32'(ed));
        check($sformatf("%s_r%0dc%0d_o8", tag, r, c), 32'(taps[8]), 32'(off + 5 * r + c));
        if (wv) windows++;
        if (fd) dones++;
        if (ev) begin
            base = off + 5 * (r - 2) + (c - 2);
            for (int i = 0; i < 9; i++) begin
                check($sformatf("%s_r%0dc%0d_tap%0d", tag, r, c, i), 32'(taps[i]), 32'(base + offs[i]));
            end
        end
    endtask

    // One frame of beats 0..19; with gap, an idle cycle follows each beat.
    task automatic run_frame(input string tag, input logic gap);
        windows = 0;
        dones   = 0;
        for (int p = 0; p < W * H; p++) begin
            cycle(1'b1, PW'(p), 1'b0, 1'b0);
            check_beat(tag, p / W, p % W, 0);
            if (gap) begin
                cycle(1'b0, 8'hAA, 1'b0, 1'b0);
                check($sformatf("%s_idle%0d_valid", tag, p), 32'(wv), 32'd0);
                check($sformatf("%s_idle%0d_done", tag, p), 32'(fd), 32'd0);
                check($sformatf("%s_idle%0d_hold", tag, p), 32'(taps[8]), 32'(p));
            end
        end
        check({tag, "_windows"}, 32'(windows), 32'd6);
        check({tag, "_dones"}, 32'(dones), 32'd1);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        pixel       = 8'd0;
        pixel_valid = 1'b0;
        sof         = 1'b0;

        do_reset();
        check_zero("reset");

        // Continuous frame, then a second frame with no reset.
        run_frame("cont", 1'b0);
        check("cont_last_o0", 32'(taps[0]), 32'd7);
        check("cont_last_o8", 32'(taps[8]), 32'd19);
        run_frame("b2b", 1'b0);

        // Alternating valid and idle cycles.
        do_reset();
        run_frame("gap", 1'b1);

        // Mid-frame sof on beat 7: stream continues 7, 8, ... with the sof beat as (0,0).
        do_reset();
        for (int p = 0; p < 7; p++) begin
            cycle(1'b1, PW'(p), 1'b0, 1'b0);
        end
        windows = 0;
        for (int q = 0; q < W * H; q++) begin
            cycle(1'b1, PW'(7 + q), (q == 0) ? 1'b1 : 1'b0, 1'b0);
            check_beat("sof", q / W, q % W, 7);
            if (q == 11) check("sof_no_early_win", 32'(windows), 32'd0);
            if (q == 12) check("sof_first_o8", 32'(taps[8]), 32'd19);
        end

        // Reset one cycle after beat 13, with a competing valid beat that must be ignored.
        do_reset();
        for (int p = 0; p < 14; p++) begin
            cycle(1'b1, PW'(p), 1'b0, 1'b0);
        end
        check("pre_rst_valid", 32'(wv), 32'd1);
        cycle(1'b1, 8'd99, 1'b0, 1'b1);
        check_zero("midrst");
        windows = 0;
        for (int p = 0; p < 13; p++) begin
            cycle(1'b1, PW'(p), 1'b0, 1'b0);
            check_beat("postrst", p / W, p % W, 0);
            if (p == 11) check("postrst_no_early_win", 32'(windows), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
